// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and constants for the transmit serializer and the
// receive-side timing logic.
//   tx_state_t                 : transmit FSM state encoding
//   UART_CLKS_PER_BIT_DEFAULT  : sysclk cycles per bit at the board baud rate
//   UART_SAMPLE_POINT          : mid-bit sample offset used by the receive path
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 5208;
   localparam int unsigned UART_SAMPLE_POINT         = 2603;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period with a one-cycle tick.
// Ports:
//   sysclk  : system clock, rising edge
//   reset   : asynchronous active-high reset
//   clear   : synchronous clear to 0 (has priority over enable)
//   enable  : advance the counter
//   tick_c  : high on the final cycle of a bit period (combinational)
// ----------------------------------------------------------------------------
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick_c
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Bit-period counter, wraps on the tick
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign tick_c = enable && !clear && (cnt == LAST);

endmodule : uart_baud_tick

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmitter: accepts one word over valid/ready and shifts it out
// LSB-first as a start / data / [parity] / stop frame.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1);
// otherwise the frame is 8N1 and no parity logic exists.
// Ports:
//   sysclk   : system clock, rising edge
//   reset    : asynchronous active-high reset
//   tx_data  : word to send, sampled only on accept
//   tx_valid : producer has data
//   tx_ready : can accept (IDLE only)
//   tx       : serial line, idle high
//   busy     : frame in progress
// ----------------------------------------------------------------------------
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   tx_state_t              state;
   logic [DATA_BITS-1:0]   shreg;
   logic [BW-1:0]          bit_idx;
   logic                   accept_c;
   logic                   baud_clear_c;
   logic                   baud_en_c;
   logic                   tick_c;
`ifdef UART_TX_PARITY_EN
   logic                   parity;
`endif

   assign accept_c     = tx_valid && tx_ready;
   // Counter restarts on accept so the start bit is a full period
   assign baud_clear_c = accept_c || (state == IDLE);
   assign baud_en_c    = (state != IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .sysclk (sysclk),
      .reset  (reset),
      .clear  (baud_clear_c),
      .enable (baud_en_c),
      .tick_c (tick_c)
   );

   // Frame FSM; tx is driven one state ahead so it is always a flop output
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (accept_c) begin
                  shreg    <= tx_data;
                  bit_idx  <= '0;
                  state    <= START;
                  tx       <= 1'b0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  parity   <= ^tx_data;
`endif
               end
            end

            START: begin
               if (tick_c) begin
                  state <= DATA;
                  tx    <= shreg[0];
               end
            end

            DATA: begin
               if (tick_c) begin
                  shreg <= shreg >> 1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= PARITY;
                     tx      <= parity;
`else
                     state   <= STOP;
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                     // Next bit is shreg[1] before the shift lands
                     tx      <= shreg[1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick_c) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
`endif

            STOP: begin
               if (tick_c) begin
                  state    <= IDLE;
                  tx       <= 1'b1;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               tx_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule : uart_tx_serializer
